vga_sync_gen: RTL and testbench

- Consumer of the 50.0 MHz pixel clock produced by the PLL clock generator.
- Generates 800x600@72Hz VGA timing: hsync, vsync, active-video flag, pixel coordinates and frame/line strobes for the pong renderer.
- Sits between the clock generator and the game/render logic, entirely in the px_clk domain.

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_sync_gen_axis_counter.sv | 42 ++++
 rtl/vga_sync_gen.sv | 111 +++++++++++
 tb/tb_vga_sync_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 800x600@72Hz timing constants and widths
package vga_timing_pkg;

    localparam int CNT_W   = 11;
    localparam int COORD_W = 10;

    localparam int VGA_H_ACTIVE = 800;
    localparam int VGA_H_FP     = 56;
    localparam int VGA_H_SYNC   = 120;
    localparam int VGA_H_BP     = 64;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 600;
    localparam int VGA_V_FP     = 37;
    localparam int VGA_V_SYNC   = 6;
    localparam int VGA_V_BP     = 23;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam logic VGA_H_POL = 1'b1;
    localparam logic VGA_V_POL = 1'b1;

    localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

endpackage

// File: rtl/vga_sync_gen_axis_counter.sv
// rtl/vga_sync_gen_axis_counter.sv - one timing axis: counter plus active/sync decode
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   ACTIVE = VGA_H_ACTIVE,
    parameter int   FP     = VGA_H_FP,
    parameter int   SYNC   = VGA_H_SYNC,
    parameter int   BP     = VGA_H_BP,
    parameter logic POL    = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             active,
    output logic             sync
);

    localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam int SYNC_START = ACTIVE + FP;
    localparam int SYNC_END   = SYNC_START + SYNC - 1;

    generate
        if (TOTAL > 2047) begin : g_total_check
            $error("vga_axis_counter: TOTAL exceeds 11-bit counter range");
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (step) begin
            count <= wrap ? '0 : count + CNT_W'(1);
        end
    end

    assign wrap   = (count == CNT_W'(TOTAL - 1));
    assign active = (count < CNT_W'(ACTIVE));
    assign sync   = (count >= CNT_W'(SYNC_START) && count <= CNT_W'(SYNC_END)) ? POL : ~POL;

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA sync/coordinate generator with registered outputs
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic H_POL    = VGA_H_POL,
    parameter logic V_POL    = VGA_V_POL
) (
    input  logic               px_clk,
    input  logic               reset,
    input  logic               px_ce,
    output logic               hsync,
    output logic               vsync,
    output logic               activevideo,
    output logic [COORD_W-1:0] x_px,
    output logic [COORD_W-1:0] y_px,
    output logic               line_end,
    output logic               frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_total_check
            $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed 11-bit counter range");
        end
    endgenerate

    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic             h_wrap;
    logic             v_wrap;
    logic             h_act;
    logic             v_act;
    logic             h_sync;
    logic             v_sync;
    logic             at_origin;
    logic             in_active;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_POL)
    ) u_h_axis (
        .clk    (px_clk),
        .reset  (reset),
        .step   (px_ce),
        .count  (h_count),
        .wrap   (h_wrap),
        .active (h_act),
        .sync   (h_sync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_POL)
    ) u_v_axis (
        .clk    (px_clk),
        .reset  (reset),
        .step   (px_ce & h_wrap),
        .count  (v_count),
        .wrap   (v_wrap),
        .active (v_act),
        .sync   (v_sync)
    );

    assign in_active = h_act & v_act;

    // Counters sit at (0,0) after reset or after stepping past the last pixel of a frame.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            at_origin <= 1'b1;
        end else if (px_ce) begin
            at_origin <= h_wrap & v_wrap;
        end
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            activevideo <= 1'b0;
            x_px        <= '0;
            y_px        <= '0;
            line_end    <= 1'b0;
            frame_start <= 1'b0;
        end else if (px_ce) begin
            hsync       <= h_sync;
            vsync       <= v_sync;
            activevideo <= in_active;
            x_px        <= in_active ? COORD_W'(h_count) : '0;
            y_px        <= in_active ? COORD_W'(v_count) : '0;
            line_end    <= h_wrap;
            frame_start <= at_origin;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen
module tb_vga_sync_gen;

    typedef struct packed {
        logic       av;
        logic       hs;
        logic       vs;
        logic [9:0] x;
        logic [9:0] y;
        logic       le;
        logic       fs;
    } out_t;

    typedef struct {
        logic rst;
        logic ce;
        int   n;
        out_t exp;
    } vec_t;

    logic       px_clk;
    logic       reset;
    logic       px_ce;
    logic       hs_b, vs_b, av_b, le_b, fs_b;
    logic [9:0] x_b, y_b;
    logic       hs_s, vs_s, av_s, le_s, fs_s;
    logic [9:0] x_s, y_s;
    out_t       big_o;
    out_t       sml_o;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  k_big   = 0;
    int  k_sml   = 0;
    logic chk_en = 1'b0;

    vga_sync_gen dut (
        .px_clk      (px_clk),
        .reset       (reset),
        .px_ce       (px_ce),
        .hsync       (hs_b),
        .vsync       (vs_b),
        .activevideo (av_b),
        .x_px        (x_b),
        .y_px        (y_b),
        .line_end    (le_b),
        .frame_start (fs_b)
    );

    vga_sync_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) dut_s (
        .px_clk      (px_clk),
        .reset       (reset),
        .px_ce       (px_ce),
        .hsync       (hs_s),
        .vsync       (vs_s),
        .activevideo (av_s),
        .x_px        (x_s),
        .y_px        (y_s),
        .line_end    (le_s),
        .frame_start (fs_s)
    );

    assign big_o = '{av: av_b, hs: hs_b, vs: vs_b, x: x_b, y: y_b, le: le_b, fs: fs_b};
    assign sml_o = '{av: av_s, hs: hs_s, vs: vs_s, x: x_s, y: y_s, le: le_s, fs: fs_s};

    initial px_clk = 1'b0;
    always #5 px_clk = ~px_clk;

    function automatic out_t mk(logic av, logic hs, logic vs, int x, int y, logic le, logic fs);
        out_t o;
        o.av = av; o.hs = hs; o.vs = vs;
        o.x = 10'(x); o.y = 10'(y);
        o.le = le; o.fs = fs;
        return o;
    endfunction

    // k = enabled edges since reset; output k shows pixel (k-1) of the raster.
    function automatic out_t model(int k, int ha, int hfp, int hsw, int hbp,
                                   int va, int vfp, int vsw, int vbp);
        int ht, vt, p, h, v;
        out_t o;
        o = '0;
        if (k == 0) return o;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        p  = (k - 1) % (ht * vt);
        h  = p % ht;
        v  = p / ht;
        o.av = (h < ha) && (v < va);
        o.hs = (h >= ha + hfp) && (h < ha + hfp + hsw);
        o.vs = (v >= va + vfp) && (v < va + vfp + vsw);
        o.x  = o.av ? 10'(h) : 10'd0;
        o.y  = o.av ? 10'(v) : 10'd0;
        o.le = (h == ht - 1);
        o.fs = (p == 0);
        return o;
    endfunction

    task automatic check_out(input string name, input out_t act, input out_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: actual av=%b hs=%b vs=%b x=%0d y=%0d le=%b fs=%b, required av=%b hs=%b vs=%b x=%0d y=%0d le=%b fs=%b",
                         name, act.av, act.hs, act.vs, act.x, act.y, act.le, act.fs,
                         exp.av, exp.hs, exp.vs, exp.x, exp.y, exp.le, exp.fs);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic c);
        reset = r;
        px_ce = c;
        @(negedge px_clk);
    endtask

    always @(posedge px_clk) begin
        if (reset) begin
            k_big <= 0;
            k_sml <= 0;
        end else if (px_ce) begin
            k_big <= k_big + 1;
            k_sml <= k_sml + 1;
        end
    end

    always @(negedge px_clk) begin
        if (chk_en) begin
            check_out("model_big", big_o, model(k_big, 800, 56, 120, 64, 600, 37, 6, 23));
            check_out("model_small", sml_o, model(k_sml, 8, 2, 3, 2, 4, 1, 2, 1));
        end
    end

    vec_t tbl[17];

    initial begin
        int av_cnt, hs_cnt, hs_first, le_cnt, le_at, le_rises, fs_cnt;
        logic le_prev;

        tbl[0]  = '{1'b1, 1'b1, 1,  mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{1'b0, 1'b1, 1,  mk(1, 0, 0, 0, 0, 0, 1)};
        tbl[2]  = '{1'b0, 1'b0, 3,  mk(1, 0, 0, 0, 0, 0, 1)};
        tbl[3]  = '{1'b0, 1'b1, 1,  mk(1, 0, 0, 1, 0, 0, 0)};
        tbl[4]  = '{1'b0, 1'b1, 7,  mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[5]  = '{1'b0, 1'b1, 2,  mk(0, 1, 0, 0, 0, 0, 0)};
        tbl[6]  = '{1'b0, 1'b1, 2,  mk(0, 1, 0, 0, 0, 0, 0)};
        tbl[7]  = '{1'b0, 1'b1, 1,  mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[8]  = '{1'b0, 1'b1, 1,  mk(0, 0, 0, 0, 0, 1, 0)};
        tbl[9]  = '{1'b0, 1'b1, 1,  mk(1, 0, 0, 0, 1, 0, 0)};
        tbl[10] = '{1'b0, 1'b1, 60, mk(0, 0, 1, 0, 0, 0, 0)};
        tbl[11] = '{1'b0, 1'b1, 14, mk(0, 0, 1, 0, 0, 1, 0)};
        tbl[12] = '{1'b0, 1'b1, 30, mk(0, 0, 0, 0, 0, 1, 0)};
        tbl[13] = '{1'b0, 1'b1, 1,  mk(1, 0, 0, 0, 0, 0, 1)};
        tbl[14] = '{1'b1, 1'b0, 1,  mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[15] = '{1'b0, 1'b0, 2,  mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[16] = '{1'b0, 1'b1, 1,  mk(1, 0, 0, 0, 0, 0, 1)};

        reset = 1'b1;
        px_ce = 1'b0;
        @(negedge px_clk);
        @(negedge px_clk);
        chk_en = 1'b1;

        for (int i = 0; i < 17; i++) begin
            for (int j = 0; j < tbl[i].n; j++) cyc(tbl[i].rst, tbl[i].ce);
            check_out($sformatf("tbl[%0d]", i), sml_o, tbl[i].exp);
        end

        // Two full lines at 800x600 with px_ce held high.
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        check_out("first_after_reset", big_o, mk(1, 0, 0, 0, 0, 0, 1));
        av_cnt = 1; hs_cnt = 0; hs_first = -1; le_cnt = 0; le_at = -1;
        for (int i = 2; i <= 2080; i++) begin
            cyc(1'b0, 1'b1);
            if (av_b) av_cnt++;
            if (hs_b) begin
                if (hs_first < 0) hs_first = i;
                hs_cnt++;
            end
            if (le_b) begin
                le_cnt++;
                le_at = i;
            end
        end
        check_int("line_active_cycles", av_cnt, 1600);
        check_int("hsync_first_cycle", hs_first, 857);
        check_int("hsync_cycles", hs_cnt, 240);
        check_int("line_end_count", le_cnt, 2);
        check_int("line_end_last_cycle", le_at, 2080);

        // Alternating px_ce doubles every interval and holds pulses for two cycles.
        cyc(1'b1, 1'b1);
        av_cnt = 0; le_cnt = 0; le_rises = 0; le_at = -1; fs_cnt = 0; le_prev = 1'b0;
        for (int i = 1; i <= 4160; i++) begin
            cyc(1'b0, logic'(i % 2));
            if (av_b) av_cnt++;
            if (fs_b) fs_cnt++;
            if (le_b) le_cnt++;
            if (le_b && !le_prev) begin
                le_rises++;
                if (le_at < 0) le_at = i;
            end
            le_prev = le_b;
        end
        check_int("toggle_active_cycles", av_cnt, 3200);
        check_int("toggle_line_end_cycles", le_cnt, 4);
        check_int("toggle_line_end_pulses", le_rises, 2);
        check_int("toggle_line_end_first", le_at, 2079);
        check_int("toggle_frame_start_cycles", fs_cnt, 2);

        // Reset mid-line aborts immediately.
        cyc(1'b1, 1'b1);
        for (int i = 0; i < 2 * 1040 + 401; i++) cyc(1'b0, 1'b1);
        check_out("pixel_400_2", big_o, mk(1, 0, 0, 400, 2, 0, 0));
        cyc(1'b1, 1'b1);
        check_out("mid_reset", big_o, mk(0, 0, 0, 0, 0, 0, 0));
        cyc(1'b0, 1'b1);
        check_out("restart_origin", big_o, mk(1, 0, 0, 0, 0, 0, 1));

        for (int i = 0; i < 20000; i++) begin
            cyc(logic'($urandom_range(0, 2999) == 0), logic'($urandom_range(0, 3) != 0));
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
